// File: rtl/ssd_scan_ctrl.sv
// Eight-digit common-anode seven-segment scan controller with per-slot anti-ghost blanking,
// frame-synchronous data shadowing, digit masking and leading-zero blanking.
module ssd_scan_ctrl #(
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic        ssd_scan_clk,
  input  logic        ssd_scan_rst,
  input  logic        ssd_scan_en,
  input  logic [31:0] ssd_scan_data,
  input  logic [7:0]  ssd_scan_digit_en,
  input  logic        ssd_scan_lzb,
  output logic [6:0]  ssd_scan_cc,
  output logic [7:0]  ssd_scan_an,
  output logic [2:0]  ssd_scan_digit,
  output logic        ssd_scan_frame
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] SlotLast  = CntW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StOff, StBlank, StShow} state_e;

  state_e          r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]      r_idx, w_idx_nxt;
  logic [31:0]     r_shadow, w_shadow_nxt;
  logic [7:0]      r_an, w_an_nxt;
  logic [6:0]      r_cc, w_cc_nxt;
  logic            r_frame, w_frame_nxt;
  logic [3:0]      w_nib;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // True when nibble i and every more significant nibble are zero.
  function automatic logic upper_zero(input logic [31:0] v, input logic [2:0] i);
    logic z;
    z = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j >= int'(i) && v[4*j +: 4] != 4'h0) z = 1'b0;
    end
    return z;
  endfunction

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_shadow_nxt = r_shadow;
    w_frame_nxt  = 1'b0;
    if (!ssd_scan_en) begin
      w_state_nxt = StOff;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        StOff: begin
          w_state_nxt  = StBlank;
          w_cnt_nxt    = '0;
          w_idx_nxt    = '0;
          w_shadow_nxt = ssd_scan_data;
          w_frame_nxt  = 1'b1;
        end
        StBlank: begin
          w_cnt_nxt = r_cnt + CntW'(1);
          if (r_cnt == BlankLast) w_state_nxt = StShow;
        end
        StShow: begin
          if (r_cnt == SlotLast) begin
            w_state_nxt = StBlank;
            w_cnt_nxt   = '0;
            w_idx_nxt   = r_idx + 3'd1;
            if (r_idx == 3'd7) begin
              w_shadow_nxt = ssd_scan_data;
              w_frame_nxt  = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CntW'(1);
          end
        end
        default: w_state_nxt = StOff;
      endcase
    end
  end

  // Outputs are derived from the next state so an/cc register on the same edge as the state.
  always_comb begin
    w_an_nxt = 8'hFF;
    w_cc_nxt = 7'h7F;
    w_nib    = w_shadow_nxt[4*w_idx_nxt +: 4];
    if (w_state_nxt == StShow) begin
      w_cc_nxt = seg_decode(w_nib);
      w_an_nxt = ~(8'b1 << w_idx_nxt);
      if (!ssd_scan_digit_en[w_idx_nxt] ||
          (ssd_scan_lzb && w_idx_nxt != 3'd0 && upper_zero(w_shadow_nxt, w_idx_nxt))) begin
        w_an_nxt = 8'hFF;
      end
    end
  end

  always_ff @(posedge ssd_scan_clk) begin
    if (!ssd_scan_rst) begin
      r_state  <= StOff;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_an     <= 8'hFF;
      r_cc     <= 7'h7F;
      r_frame  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_shadow <= w_shadow_nxt;
      r_an     <= w_an_nxt;
      r_cc     <= w_cc_nxt;
      r_frame  <= w_frame_nxt;
    end
  end

  assign ssd_scan_an    = r_an;
  assign ssd_scan_cc    = r_cc;
  assign ssd_scan_digit = r_idx;
  assign ssd_scan_frame = r_frame;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl: per-slot expectations are queued when a frame's data is
// driven and popped as each slot starts showing, with every cycle of the frame checked.
module tb_ssd_scan_ctrl;

  localparam int unsigned TickDiv = 8;
  localparam int unsigned Blank   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] data;
  logic [7:0]  digit_en;
  logic        lzb;
  logic [6:0]  cc;
  logic [7:0]  an;
  logic [2:0]  digit;
  logic        frame;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] cc;
    logic       lit;
  } exp_t;

  exp_t q[$];

  ssd_scan_ctrl #(
    .TICK_DIV     (TickDiv),
    .BLANK_CYCLES (Blank)
  ) dut (
    .ssd_scan_clk      (clk),
    .ssd_scan_rst      (rst),
    .ssd_scan_en       (en),
    .ssd_scan_data     (data),
    .ssd_scan_digit_en (digit_en),
    .ssd_scan_lzb      (lzb),
    .ssd_scan_cc       (cc),
    .ssd_scan_an       (an),
    .ssd_scan_digit    (digit),
    .ssd_scan_frame    (frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40; 4'h1: g = 7'h79; 4'h2: g = 7'h24; 4'h3: g = 7'h30;
      4'h4: g = 7'h19; 4'h5: g = 7'h12; 4'h6: g = 7'h02; 4'h7: g = 7'h78;
      4'h8: g = 7'h00; 4'h9: g = 7'h10; 4'hA: g = 7'h08; 4'hB: g = 7'h03;
      4'hC: g = 7'h46; 4'hD: g = 7'h21; 4'hE: g = 7'h06; default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Queue the eight slot results expected for a frame that latches d.
  task automatic push_frame(input logic [31:0] d, input logic [7:0] m, input logic z);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] upper;
      upper = d >> (4 * i);
      e.lit = m[i] && !(z && i != 0 && upper == 32'h0);
      e.an  = e.lit ? (8'hFF ^ (8'h01 << i)) : 8'hFF;
      e.cc  = glyph(upper[3:0]);
      q.push_back(e);
    end
  endtask

  // Called at the sample point of the first cycle of a frame; returns at the next frame's start.
  task automatic check_frame(input int chg_slot, input logic [31:0] chg_data);
    exp_t e;
    e = '0;
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < int'(TickDiv); c++) begin
        chk("frame", 32'(frame), 32'((s == 0 && c == 0) ? 1 : 0));
        chk("digit", 32'(digit), 32'(s));
        if (c < int'(Blank)) begin
          chk("blank_an", 32'(an), 32'hFF);
          chk("blank_cc", 32'(cc), 32'h7F);
        end else begin
          if (c == int'(Blank)) begin
            if (q.size() == 0) begin
              chk("queue_empty", 32'(q.size()), 32'd1);
            end else begin
              e = q.pop_front();
            end
          end
          chk("show_an", 32'(an), 32'(e.an));
          if (e.lit) chk("show_cc", 32'(cc), 32'(e.cc));
        end
        if (s == chg_slot && c == 4) data = chg_data;
        tick();
      end
    end
  endtask

  // Park in OFF for a cycle, apply the configuration, then enable (frame begins on that edge).
  task automatic start(input logic [31:0] d, input logic [7:0] m, input logic z);
    en = 1'b0;
    tick();
    data     = d;
    digit_en = m;
    lzb      = z;
    en       = 1'b1;
    tick();
  endtask

  initial begin
    rst      = 1'b0;
    en       = 1'b1;
    data     = 32'hFFFFFFFF;
    digit_en = 8'hFF;
    lzb      = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_an", 32'(an), 32'hFF);
      chk("rst_cc", 32'(cc), 32'h7F);
      chk("rst_frame", 32'(frame), 32'd0);
      chk("rst_digit", 32'(digit), 32'd0);
    end
    rst = 1'b1;
    tick();
    chk("rel_frame", 32'(frame), 32'd1);
    chk("rel_an", 32'(an), 32'hFF);

    // Basic scan over two consecutive frames
    start(32'h76543210, 8'hFF, 1'b0);
    push_frame(32'h76543210, 8'hFF, 1'b0);
    check_frame(-1, 32'h0);
    push_frame(32'h76543210, 8'hFF, 1'b0);
    check_frame(-1, 32'h0);

    // Leading-zero blanking
    start(32'h00000A05, 8'hFF, 1'b1);
    push_frame(32'h00000A05, 8'hFF, 1'b1);
    check_frame(-1, 32'h0);
    start(32'h00000000, 8'hFF, 1'b1);
    push_frame(32'h00000000, 8'hFF, 1'b1);
    check_frame(-1, 32'h0);

    // Digit mask keeps slot timing
    start(32'h89ABCDEF, 8'h0F, 1'b0);
    push_frame(32'h89ABCDEF, 8'h0F, 1'b0);
    check_frame(-1, 32'h0);
    push_frame(32'h89ABCDEF, 8'h0F, 1'b0);
    check_frame(-1, 32'h0);

    // Mid-frame data change is held off until the next frame
    start(32'h11111111, 8'hFF, 1'b0);
    push_frame(32'h11111111, 8'hFF, 1'b0);
    check_frame(3, 32'h22222222);
    push_frame(32'h22222222, 8'hFF, 1'b0);
    check_frame(-1, 32'h0);

    // Abort by en mid-SHOW
    start(32'h76543210, 8'hFF, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("pre_abort_an", 32'(an), 32'hFB);
    en = 1'b0;
    tick();
    chk("abort_an", 32'(an), 32'hFF);
    chk("abort_cc", 32'(cc), 32'h7F);
    chk("abort_digit", 32'(digit), 32'd0);
    chk("abort_frame", 32'(frame), 32'd0);
    data = 32'hFEDCBA98;
    en   = 1'b1;
    tick();
    push_frame(32'hFEDCBA98, 8'hFF, 1'b0);
    check_frame(-1, 32'h0);

    // Abort by reset mid-SHOW
    for (int i = 0; i < 28; i++) tick();
    chk("pre_rst_an", 32'(an), 32'hF7);
    rst = 1'b0;
    tick();
    chk("mrst_an", 32'(an), 32'hFF);
    chk("mrst_cc", 32'(cc), 32'h7F);
    chk("mrst_digit", 32'(digit), 32'd0);
    chk("mrst_frame", 32'(frame), 32'd0);
    data = 32'h31415926;
    rst  = 1'b1;
    tick();
    push_frame(32'h31415926, 8'hFF, 1'b0);
    check_frame(-1, 32'h0);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
# ssd_scan_ctrl

Time-multiplexed scan controller for the 8-digit common-anode seven-segment display on the board. It shares the single cathode bus among eight digit anodes by cycling through slots at a fixed rate. Each slot inserts an anti-ghosting blank interval, and the block decodes the 4-bit value for the active digit into segment drive. It sits between the hex/BCD counter datapath, which supplies a 32-bit nibble-packed value, and the board's cathode and anode pins.

## Interface
- TICK_DIV, 100000: clock cycles per digit slot, blank interval included (1 ms at 100 MHz). Must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 4: cycles at the start of each slot with all anodes off. Must be at least 1.

- ssd_scan_clk  in  1  system clock, 100 MHz.
- ssd_scan_rst  in  1  reset. Synchronous and active-low.
- ssd_scan_en  in  1  scan enable. When 0, all anodes are off.
- ssd_scan_data  in  32  eight nibbles. Digit i is data[4i+3:4i], and digit 0 is rightmost.
- ssd_scan_digit_en  in  8  per-digit enable mask.
- ssd_scan_lzb  in  1  leading-zero blanking enable.
- ssd_scan_cc  out  7  cathodes, active-low, {g,f,e,d,c,b,a}.
- ssd_scan_an  out  8  anodes, active-low. Bit i drives digit i.
- ssd_scan_digit  out  3  index of the current slot.
- ssd_scan_frame  out  1  one-cycle pulse in the first cycle of slot 0 of every frame.

## Operation
- FSM states are OFF, BLANK and SHOW. Registers: slot counter cnt (0..TICK_DIV-1), index idx (0..7), and a 32-bit shadow register.
- OFF → BLANK when en=1. On that edge: cnt=0, idx=0, shadow<=data, frame=1.
- BLANK → SHOW when cnt reaches BLANK_CYCLES-1.
- SHOW → BLANK when cnt reaches TICK_DIV-1. On that edge: cnt=0 and idx=idx+1 mod 8.
  - When idx wraps from 7 to 0, also shadow<=data and frame=1.
- Any state → OFF when en=0. Takes effect on the next edge, mid-slot included. cnt and idx are cleared.
- In OFF and BLANK: an=8'hFF and cc=7'h7F.
- In SHOW: an has bit idx low only, and cc is the decode of shadow nibble idx. Exceptions:
  - If digit_en[idx]=0, then an=8'hFF. The slot still lasts TICK_DIV cycles, so brightness stays uniform.
  - If lzb=1, idx≠0, and shadow nibbles idx..7 are all zero, then an=8'hFF. Digit 0 is never blanked.
- Decode gives full hex glyphs. Examples: 0=1000000, 1=1111001, 5=0010010, 8=0000000, A=0001000, F=0001110.
- The display reads only the shadow register, so data changes mid-frame never tear the display. Changes appear at the next frame start.

## Timing
- Reset values: state=OFF, cnt=0, idx=0, shadow=0, an=8'hFF, cc=7'h7F, digit=0, frame=0.
- Reset has priority over en.
- All outputs are registered Moore outputs and update on the same edge as the state. an and cc always change on the same edge.
- If en is sampled high at edge t (from OFF):
  - frame=1 and blanking start at t.
  - Digit 0 is driven from edge t+BLANK_CYCLES.
- Slot length is exactly TICK_DIV cycles: BLANK_CYCLES blank plus TICK_DIV-BLANK_CYCLES driven.
- Frame period is 8·TICK_DIV cycles. frame is high for exactly 1 cycle per frame.
- digit equals idx in every state.

## Test plan
Benches use TICK_DIV=8 and BLANK_CYCLES=2.
- Reset: hold rst=0 for 3 cycles with en=1 and data=32'hFFFFFFFF → an=FF, cc=7F, frame=0 throughout. Release → frame=1 one cycle later.
- Basic scan: data=32'h76543210, mask=FF, lzb=0, en=1 → each slot is 2 cycles an=FF then 6 cycles with digit i lit. Digit 0 shows an=FE, cc=1000000; digit 7 shows an=7F. frame pulses every 64 cycles.
- Leading-zero blanking: data=32'h00000A05, lzb=1 → digits 0, 1, 2 show 5, 0, A; slots 3-7 give an=FF. With data=0, only digit 0 shows 0.
- Mask: digit_en=8'h0F → slots 4-7 give an=FF for 8 cycles each. Frame period stays 64 cycles.
- Tearing: change data from 32'h11111111 to 32'h22222222 during slot 3 → slots 4-7 still show 1. The new value appears from the next frame's slot 0, on the frame pulse.
- Abort: drop en mid-SHOW → an=FF and cc=7F on the next edge. Re-enable → restart at digit 0 with a frame pulse. Repeat the same sequence with rst=0 mid-slot.
